// File: rtl/venom_pkg.sv
// rtl/venom_pkg.sv - shared types and constants for the venom hit detector
//
// Holds the FSM state encoding, the default screen limits and the 11-bit
// absolute-difference helper used by the overlap comparator.
package venom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_COOLDOWN,
    ST_DEAD
  } state_t;

  localparam int X_MAX_DEFAULT = 639;
  localparam int Y_MAX_DEFAULT = 479;

  // Widened to 11 bits so the difference of two 10-bit values never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] wa;
    logic [10:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational centre/half-size box overlap test
//
// Ports:
//   a_x, a_y, a_s : first box centre and half-size (10 bits each)
//   b_x, b_y, b_s : second box centre and half-size (10 bits each)
//   overlap       : both axis distances are within the summed half-sizes
module box_overlap
  import venom_pkg::*;
(
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_s,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_s,
  output logic       overlap
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] size_sum;

  assign dx       = abs_diff(a_x, b_x);
  assign dy       = abs_diff(a_y, b_y);
  assign size_sum = {1'b0, a_s} + {1'b0, b_s};

  // Touching edges count as a hit.
  assign overlap  = (dx <= size_sum) && (dy <= size_sum);

endmodule

// File: rtl/venom_hit_detector.sv
// rtl/venom_hit_detector.sv - projectile vs target hit detection with health and invulnerability
//
// Ports:
//   Clk, Reset_n            : clock and asynchronous active-low reset
//   frame_tick              : one-cycle strobe per frame
//   venomMovement           : projectile in flight
//   VenomX/Y/S              : projectile centre and half-size
//   targetX/Y/S             : target centre and half-size
//   collision               : one-cycle pulse, projectile consumed
//   hit                     : one-cycle pulse on a target hit
//   health                  : remaining target health
//   invuln                  : post-hit cooldown active
//   gameOver                : health exhausted
module venom_hit_detector
  import venom_pkg::*;
#(
  parameter int HEALTH_INIT   = 5,
  parameter int INVULN_FRAMES = 60,
  parameter int X_MAX         = X_MAX_DEFAULT,
  parameter int Y_MAX         = Y_MAX_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       venomMovement,
  input  logic [9:0] VenomX,
  input  logic [9:0] VenomY,
  input  logic [9:0] VenomS,
  input  logic [9:0] targetX,
  input  logic [9:0] targetY,
  input  logic [9:0] targetS,
  output logic       collision,
  output logic       hit,
  output logic [2:0] health,
  output logic       invuln,
  output logic       gameOver
);

  localparam logic [9:0] X_LIM      = X_MAX[9:0];
  localparam logic [9:0] Y_LIM      = Y_MAX[9:0];
  localparam logic [2:0] HEALTH_RST = HEALTH_INIT[2:0];
  localparam logic [7:0] CNT_LOAD   = INVULN_FRAMES[7:0];

  state_t     state;
  logic [7:0] count;

  logic [9:0] cap_vx;
  logic [9:0] cap_vy;
  logic [9:0] cap_vs;
  logic [9:0] cap_tx;
  logic [9:0] cap_ty;
  logic [9:0] cap_ts;

  logic overlap;
  logic offscreen;

  box_overlap u_box_overlap (
    .a_x    (cap_vx),
    .a_y    (cap_vy),
    .a_s    (cap_vs),
    .b_x    (cap_tx),
    .b_y    (cap_ty),
    .b_s    (cap_ts),
    .overlap(overlap)
  );

  // Coordinates that wrapped below zero land above the limits as well.
  assign offscreen = (cap_vx > X_LIM) || (cap_vy > Y_LIM);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      health    <= HEALTH_RST;
      collision <= 1'b0;
      hit       <= 1'b0;
      invuln    <= 1'b0;
      gameOver  <= 1'b0;
      cap_vx    <= '0;
      cap_vy    <= '0;
      cap_vs    <= '0;
      cap_tx    <= '0;
      cap_ty    <= '0;
      cap_ts    <= '0;
    end else begin
      collision <= 1'b0;
      hit       <= 1'b0;

      // invuln trails the counter by one cycle.
      if (invuln && (count == 8'd0)) begin
        invuln <= 1'b0;
      end

      case (state)
        ST_IDLE, ST_COOLDOWN: begin
          if (frame_tick) begin
            if ((state == ST_COOLDOWN) && (count != 8'd0)) begin
              count <= count - 8'd1;
            end
            if (venomMovement) begin
              cap_vx <= VenomX;
              cap_vy <= VenomY;
              cap_vs <= VenomS;
              cap_tx <= targetX;
              cap_ty <= targetY;
              cap_ts <= targetS;
              state  <= ST_SAMPLE;
            end
          end else if ((state == ST_COOLDOWN) && (count == 8'd0)) begin
            state <= ST_IDLE;
          end
        end

        // The comparison runs combinationally off the capture registers, so
        // the result is registered here and shows up while in EVAL.
        ST_SAMPLE: begin
          if (!venomMovement) begin
            state <= (count != 8'd0) ? ST_COOLDOWN : ST_IDLE;
          end else begin
            collision <= overlap || offscreen;
            hit       <= overlap;
            state     <= ST_EVAL;
            if (overlap && !invuln) begin
              if (health <= 3'd1) begin
                health   <= 3'd0;
                gameOver <= 1'b1;
                invuln   <= 1'b0;
                count    <= 8'd0;
                state    <= ST_DEAD;
              end else begin
                health <= health - 3'd1;
                count  <= CNT_LOAD;
                invuln <= 1'b1;
              end
            end
          end
        end

        ST_EVAL: begin
          state <= (count != 8'd0) ? ST_COOLDOWN : ST_IDLE;
        end

        ST_DEAD: begin
          state <= ST_DEAD;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
